lsu_ctrl: RTL

Load/store controller that sits between the CPU datapath and the data memory `DM`, acting as the initiator of every data-memory access. It accepts byte, halfword and word loads and stores from the pipeline and issues aligned 32-bit word accesses on `DM`'s port. Sub-word stores are built as read-modify-write sequences, and sub-word loads are extracted and extended. `DM` is word-wide and big-endian: byte offset 0 maps to bits [31:24]. `DM` reads are combinational, and `DM` writes commit at the posedge.

---
 rtl/lsu_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller driving a word-wide big-endian data memory, with
// read-modify-write for sub-word stores. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;

    logic        accept_s;
    logic        size_err_s;
    logic        range_err_s;
    logic        misalign_s;
    logic        req_err_s;
    logic [31:0] aligned_addr_s;

    // Pick the addressed lane out of a big-endian word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            2'b10:   res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the captured word with the store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    res[31:24] = wdata[7:0];
                    2'd1:    res[23:16] = wdata[7:0];
                    2'd2:    res[15:8]  = wdata[7:0];
                    default: res[7:0]   = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    res[15:0] = wdata[15:0];
                end else begin
                    res[31:16] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign accept_s = req_valid && (state_q == ST_IDLE);

    // Request screening and alignment of the address that will be latched.
    always_comb begin
        size_err_s  = (req_size == 2'b11);
        range_err_s = (req_addr >= MEM_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s     = ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        aligned_addr_s = req_addr;
`else
        misalign_s = 1'b0;
        case (req_size)
            2'b01:   aligned_addr_s = {req_addr[31:1], 1'b0};
            2'b10:   aligned_addr_s = {req_addr[31:2], 2'b00};
            default: aligned_addr_s = req_addr;
        endcase
`endif
        req_err_s = size_err_s || range_err_s || misalign_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; word stores skip the read phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (req_err_s) begin
                    state_d = ST_DONE;
                end else if (req_write && (req_size == 2'b10)) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RD:   state_d = write_q ? ST_WR : ST_DONE;
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches and captured read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
        end else begin
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
        end
    end

    // Latch the request on accept; capture memory data at the end of RD.
    always_comb begin
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        signed_d = signed_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        if (accept_s) begin
            addr_d   = aligned_addr_s;
            size_d   = req_size;
            write_d  = req_write;
            signed_d = req_signed;
            err_d    = req_err_s;
            wdata_d  = req_wdata;
        end else if (state_q == ST_RD) begin
            word_d = MemReadData;
        end else begin
            word_d = word_q;
        end
    end

    // Outputs decoded from state and latches only, so reset clears them at once.
    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        resp_valid   = (state_q == ST_DONE);
        resp_err     = (state_q == ST_DONE) && err_q;
        resp_rdata   = 32'd0;
        MemAddr      = 32'd0;
        MemWriteData = 32'd0;
        MemRead      = (state_q == ST_RD);
        MemWrite     = (state_q == ST_WR);
        if ((state_q == ST_DONE) && !err_q && !write_q) begin
            resp_rdata = load_extract(word_q, addr_q[1:0], size_q, signed_q);
        end else begin
            resp_rdata = 32'd0;
        end
        if ((state_q == ST_RD) || (state_q == ST_WR)) begin
            MemAddr = {addr_q[31:2], 2'b00};
        end else begin
            MemAddr = 32'd0;
        end
        if (state_q == ST_WR) begin
            MemWriteData = (size_q == 2'b10) ? wdata_q : merge_lane(word_q, wdata_q, addr_q[1:0], size_q);
        end else begin
            MemWriteData = 32'd0;
        end
    end

endmodule
